// File: rtl/frag_reader.sv
// ---------------------------------------------------------------------------------------------
// frag_reader
//
// Purpose:
//   Read-side drain engine for a byte-granular width-changing FIFO. It watches the FIFO byte
//   level and issues one read of 1..4 bytes at a time. The byte stream is re-framed into
//   fixed-length fragments of FRAG_LEN bytes. Fragments leave as left-justified 32-bit words
//   with a valid/ready handshake, start/end-of-fragment markers and a byte count.
//
// Parameters:
//   FRAG_LEN  fragment payload length in bytes (1..65535)
//   LVL_W     width of the FIFO level and read-index buses (>= 3)
//
// Ports:
//   clk            clock
//   rst            synchronous active-high reset
//   flush          (FRAG_READER_FLUSH_EN only) terminate the current fragment with what is in
//                  the FIFO when fewer bytes than needed are available
//   fifo_level     bytes currently held in the FIFO (registered by the FIFO)
//   fifo_rd_en     one-cycle read strobe
//   fifo_rd_index  bytes requested with fifo_rd_en (1..4), 0 otherwise
//   fifo_rd_data   read data, valid the cycle after fifo_rd_en, first byte in [31:24]
//   m_valid        output word valid
//   m_ready        downstream accept
//   m_data         output word, left-justified, unused low bytes zero
//   m_bytes        valid bytes in m_data (1..4)
//   m_sof          first word of a fragment
//   m_eof          last word of a fragment
//   frag_cnt       completed fragments, wraps at 0xFFFF
//
// Optional feature macro: FRAG_READER_FLUSH_EN (adds the flush input).
// ---------------------------------------------------------------------------------------------
module frag_reader #(
    parameter int unsigned FRAG_LEN = 6,
    parameter int unsigned LVL_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
`ifdef FRAG_READER_FLUSH_EN
    input  logic             flush,
`endif
    input  logic [LVL_W-1:0] fifo_level,
    output logic             fifo_rd_en,
    output logic [LVL_W-1:0] fifo_rd_index,
    input  logic [31:0]      fifo_rd_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [31:0]      m_data,
    output logic [2:0]       m_bytes,
    output logic             m_sof,
    output logic             m_eof,
    output logic [15:0]      frag_cnt
);

    localparam logic [15:0] FragLen = 16'(FRAG_LEN);

    typedef enum logic [1:0] {
        StReq,
        StWait,
        StOut
    } state_e;

    state_e      r_state;
    state_e      w_state_next;

    logic [15:0] r_remaining;
    logic        r_first;
    logic [2:0]  r_req_bytes;
    logic        r_short;       // current word was a flushed short read
    logic [31:0] r_data;
    logic [2:0]  r_bytes;
    logic        r_valid;
    logic        r_sof;
    logic        r_eof;
    logic [15:0] r_frag_cnt;

    logic [2:0]  w_need;
    logic        w_level_ok;
    logic        w_flush_rd;
    logic [2:0]  w_rd_bytes;
    logic [31:0] w_mask;
    logic        w_handshake;

    // ---------------------------------------------------------------------------------------
    // Read sizing
    // ---------------------------------------------------------------------------------------
    assign w_need     = (r_remaining >= 16'd4) ? 3'd4 : r_remaining[2:0];
    assign w_level_ok = 32'(fifo_level) >= 32'(w_need);

`ifdef FRAG_READER_FLUSH_EN
    // A flush only matters when some, but not enough, bytes are waiting.
    assign w_flush_rd = flush && (fifo_level != '0) && !w_level_ok;
`else
    assign w_flush_rd = 1'b0;
`endif

    // On a flushed read fifo_level < need <= 4, so it fits in 3 bits.
    assign w_rd_bytes = w_level_ok ? w_need : 3'(fifo_level);

    // Keep only the requested leading bytes of the FIFO word.
    always_comb begin
        w_mask = 32'hFFFF_FFFF;
        unique case (r_req_bytes)
            3'd1:    w_mask = 32'hFF00_0000;
            3'd2:    w_mask = 32'hFFFF_0000;
            3'd3:    w_mask = 32'hFFFF_FF00;
            default: w_mask = 32'hFFFF_FFFF;
        endcase
    end

    assign w_handshake = (r_state == StOut) && r_valid && m_ready;

    // ---------------------------------------------------------------------------------------
    // FSM next state and read strobe
    // ---------------------------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        fifo_rd_en    = 1'b0;
        fifo_rd_index = '0;
        unique case (r_state)
            StReq: begin
                // Gated by rst so no read is issued while the engine is being reset.
                if (!rst && (w_level_ok || w_flush_rd)) begin
                    fifo_rd_en    = 1'b1;
                    fifo_rd_index = LVL_W'(w_rd_bytes);
                    w_state_next  = StWait;
                end
            end
            StWait: begin
                w_state_next = StOut;
            end
            StOut: begin
                if (m_ready) begin
                    w_state_next = StReq;
                end
            end
            default: begin
                w_state_next = StReq;
            end
        endcase
    end

    // ---------------------------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StReq;
            r_remaining <= FragLen;
            r_first     <= 1'b1;
            r_req_bytes <= 3'd0;
            r_short     <= 1'b0;
            r_data      <= 32'd0;
            r_bytes     <= 3'd0;
            r_valid     <= 1'b0;
            r_sof       <= 1'b0;
            r_eof       <= 1'b0;
            r_frag_cnt  <= 16'd0;
        end else begin
            r_state <= w_state_next;

            if (fifo_rd_en) begin
                r_req_bytes <= w_rd_bytes;
                r_short     <= w_flush_rd;
            end

            if (r_state == StWait) begin
                r_data  <= fifo_rd_data & w_mask;
                r_bytes <= r_req_bytes;
                r_sof   <= r_first;
                r_eof   <= (r_remaining == 16'(r_req_bytes)) || r_short;
                r_valid <= 1'b1;
            end

            if (w_handshake) begin
                r_valid <= 1'b0;
                if (r_eof) begin
                    r_remaining <= FragLen;
                    r_first     <= 1'b1;
                    r_frag_cnt  <= r_frag_cnt + 16'd1;
                end else begin
                    r_remaining <= r_remaining - 16'(r_req_bytes);
                    r_first     <= 1'b0;
                end
            end
        end
    end

    assign m_valid  = r_valid;
    assign m_data   = r_data;
    assign m_bytes  = r_bytes;
    assign m_sof    = r_sof;
    assign m_eof    = r_eof;
    assign frag_cnt = r_frag_cnt;

endmodule

// File: tb/tb_frag_reader.sv
// ---------------------------------------------------------------------------------------------
// tb_frag_reader
//
// Directed bench for frag_reader (FRAG_LEN=6, LVL_W=4). A small byte-queue model stands in for
// the FIFO: the level is registered, reads pop bytes at the clock edge and return them
// left-justified the next cycle with 0xA5 filler in the unrequested low bytes.
// Honours FRAG_READER_FLUSH_EN to exercise the flush port.
// ---------------------------------------------------------------------------------------------
module tb_frag_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
`ifdef FRAG_READER_FLUSH_EN
    logic        flush = 1'b0;
`endif
    logic [3:0]  fifo_level = 4'd0;
    logic        fifo_rd_en;
    logic [3:0]  fifo_rd_index;
    logic [31:0] fifo_rd_data = 32'd0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [31:0] m_data;
    logic [2:0]  m_bytes;
    logic        m_sof;
    logic        m_eof;
    logic [15:0] frag_cnt;

    byte unsigned fifo_q[$];
    int           n_checks = 0;
    int           n_fails  = 0;

    frag_reader #(
        .FRAG_LEN (6),
        .LVL_W    (4)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
`ifdef FRAG_READER_FLUSH_EN
        .flush         (flush),
`endif
        .fifo_level    (fifo_level),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_index (fifo_rd_index),
        .fifo_rd_data  (fifo_rd_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_bytes       (m_bytes),
        .m_sof         (m_sof),
        .m_eof         (m_eof),
        .frag_cnt      (frag_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pop_word(int n);
        logic [31:0] w;
        w = 32'hA5A5_A5A5;
        for (int i = 0; i < n; i++) begin
            if (fifo_q.size() > 0) w[31-8*i -: 8] = fifo_q.pop_front();
        end
        return w;
    endfunction

    // FIFO model: read data and level both registered.
    always @(posedge clk) begin
        if (fifo_rd_en) fifo_rd_data <= pop_word(int'(fifo_rd_index));
        fifo_level <= 4'(fifo_q.size());
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input byte unsigned b);
        fifo_q.push_back(b);
    endtask

    // Advance at least one negedge, up to a bound, until a read strobe appears.
    task automatic wait_rd(input string tag, input logic [3:0] exp_idx);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (fifo_rd_en) break;
        end
        check({tag, "_rd_en"}, 32'(fifo_rd_en), 32'd1);
        check({tag, "_rd_index"}, 32'(fifo_rd_index), 32'(exp_idx));
    endtask

    // Word appears two cycles after the read strobe.
    task automatic check_word(input string tag, input logic [31:0] data, input logic [2:0] nb,
                              input logic sof, input logic eof);
        @(negedge clk);
        @(negedge clk);
        check({tag, "_valid"}, 32'(m_valid), 32'd1);
        check({tag, "_data"}, m_data, data);
        check({tag, "_bytes"}, 32'(m_bytes), 32'(nb));
        check({tag, "_sof"}, 32'(m_sof), 32'(sof));
        check({tag, "_eof"}, 32'(m_eof), 32'(eof));
    endtask

    task automatic count_idle(input string tag, input int cycles);
        int n;
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (fifo_rd_en) n++;
        end
        check({tag, "_no_rd"}, 32'(n), 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_data", m_data, 32'd0);
        check("rst_bytes", 32'(m_bytes), 32'd0);
        check("rst_sof_eof", 32'({m_sof, m_eof}), 32'd0);
        check("rst_rd", 32'({fifo_rd_en, fifo_rd_index}), 32'd0);
        check("rst_cnt", 32'(frag_cnt), 32'd0);
        rst = 1'b0;

        // Full first word, then 2-byte tail closes the fragment
        push(8'h12); push(8'h34); push(8'h56); push(8'h78);
        wait_rd("w1", 4'd4);
        check_word("w1", 32'h1234_5678, 3'd4, 1'b1, 1'b0);
        push(8'h11); push(8'h22);
        wait_rd("w2", 4'd2);
        check_word("w2", 32'h1122_0000, 3'd2, 1'b0, 1'b1);
        @(negedge clk);
        check("w2_cnt", 32'(frag_cnt), 32'd1);
        check("w2_valid_drop", 32'(m_valid), 32'd0);

        // Insufficient level stalls the read
        push(8'hAA); push(8'hBB); push(8'hCC);
        count_idle("stall", 20);
        push(8'hDD);
        @(negedge clk);
        check("stall_rd_en", 32'(fifo_rd_en), 32'd1);
        check("stall_rd_index", 32'(fifo_rd_index), 32'd4);
        check_word("w3", 32'hAABB_CCDD, 3'd4, 1'b1, 1'b0);
        push(8'hEE); push(8'hFF);
        wait_rd("w4", 4'd2);
        check_word("w4", 32'hEEFF_0000, 3'd2, 1'b0, 1'b1);
        @(negedge clk);
        check("w4_cnt", 32'(frag_cnt), 32'd2);

        // Backpressure with 8 bytes waiting
        m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(8'(i));
        wait_rd("bp", 4'd4);
        check_word("bp", 32'h0102_0304, 3'd4, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(m_valid), 32'd1);
            check("bp_hold_data", m_data, 32'h0102_0304);
            check("bp_hold_no_rd", 32'(fifo_rd_en), 32'd0);
        end
        m_ready = 1'b1;
        @(negedge clk);
        check("bp_next_rd_en", 32'(fifo_rd_en), 32'd1);
        check("bp_next_rd_index", 32'(fifo_rd_index), 32'd2);
        check_word("bp2", 32'h0506_0000, 3'd2, 1'b0, 1'b1);
        @(negedge clk);
        check("bp2_cnt", 32'(frag_cnt), 32'd3);

        // Reset while holding the first word of a fragment
        m_ready = 1'b0;
        push(8'h09); push(8'h0A);
        wait_rd("pre_rst", 4'd4);
        check_word("pre_rst", 32'h0708_090A, 3'd4, 1'b1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", 32'(m_valid), 32'd0);
        check("mid_rst_data", m_data, 32'd0);
        check("mid_rst_bytes", 32'(m_bytes), 32'd0);
        check("mid_rst_sof_eof", 32'({m_sof, m_eof}), 32'd0);
        check("mid_rst_cnt", 32'(frag_cnt), 32'd0);
        check("mid_rst_rd", 32'(fifo_rd_en), 32'd0);
        rst     = 1'b0;
        m_ready = 1'b1;
        push(8'h21); push(8'h22); push(8'h23); push(8'h24);
        wait_rd("post_rst", 4'd4);
        check_word("post_rst", 32'h2122_2324, 3'd4, 1'b1, 1'b0);

`ifdef FRAG_READER_FLUSH_EN
        // One byte waiting, two needed: flush cuts the fragment short
        push(8'h5A);
        flush = 1'b1;
        wait_rd("flush", 4'd1);
        flush = 1'b0;
        check_word("flush", 32'h5A00_0000, 3'd1, 1'b0, 1'b1);
        @(negedge clk);
        check("flush_cnt", 32'(frag_cnt), 32'd1);
`else
        // Without flush a short tail waits for the rest of its bytes
        push(8'h5A);
        count_idle("tail", 10);
        push(8'h5B);
        wait_rd("tail", 4'd2);
        check_word("tail", 32'h5A5B_0000, 3'd2, 1'b0, 1'b1);
        @(negedge clk);
        check("tail_cnt", 32'(frag_cnt), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/frag_reader.md
Name: frag_reader

Overview:
- Read-side drain engine for the byte-granular width-changing FIFO (changeFIFO).
- Monitors the FIFO byte level and issues variable-length reads (1–4 bytes) via read-enable/read-index.
- Re-frames the byte stream into fixed-length fragments, emitted as 32-bit words with valid/ready handshake, start/end markers and byte count.

Parameters:
- FRAG_LEN, 6, fragment payload length in bytes; legal range 1..65535.
- LVL_W, 4, width of FIFO level and read-index buses.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- fifo_level  in  LVL_W  bytes currently held in the FIFO; registered by the FIFO.
- fifo_rd_en  out  1  one-cycle read strobe to the FIFO.
- fifo_rd_index  out  LVL_W  bytes requested with fifo_rd_en (1..4); 0 when fifo_rd_en=0.
- fifo_rd_data  in  32  FIFO read data. Valid the cycle after fifo_rd_en. First byte in [31:24], left-justified.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.
- m_data  out  32  output word, left-justified; unused low bytes are 0.
- m_bytes  out  3  valid bytes in m_data (1..4).
- m_sof  out  1  first word of fragment.
- m_eof  out  1  last word of fragment.
- frag_cnt  out  16  completed fragments; wraps at 0xFFFF->0.

Behaviour:
- Reset values:
  - m_valid, m_data, m_bytes, m_sof, m_eof, fifo_rd_en, fifo_rd_index, frag_cnt = 0.
  - remaining = FRAG_LEN.
  - first = 1.
  - state = REQ.
- Reset asserted mid-operation: the in-flight read is abandoned, its data is discarded, and the output word is dropped.
- need = min(4, remaining).
- REQ state:
  - If fifo_level >= need: assert fifo_rd_en=1 and fifo_rd_index=need for exactly one cycle, latch need into req_bytes, go to WAIT.
  - Otherwise hold in REQ; no read is issued. Partial words are never read (except under the optional feature).
- WAIT state (one cycle):
  - Register m_data = fifo_rd_data with bytes below req_bytes masked to 0.
  - m_bytes = req_bytes.
  - m_sof = first.
  - m_eof = (remaining == req_bytes).
  - m_valid = 1; go to OUT.
- OUT state:
  - Hold m_data, m_bytes, m_sof, m_eof and m_valid stable until m_ready=1.
  - On handshake:
    - m_valid <= 0.
    - remaining <= remaining - req_bytes; first <= 0.
    - If m_eof: remaining <= FRAG_LEN, first <= 1, frag_cnt <= frag_cnt + 1.
    - Go to REQ.
- Only one FIFO read is outstanding at a time, so fifo_level seen in REQ always reflects the prior read.
- Read-to-m_valid latency is 2 cycles (rd_en at cycle N, m_valid at N+2).
- Minimum word period is 3 cycles with m_ready tied high.
- m_ready may be high before m_valid; only m_valid & m_ready counts as a handshake.
- FRAG_LEN not a multiple of 4: the last word of each fragment carries FRAG_LEN mod 4 bytes.
- FRAG_LEN <= 4: m_sof and m_eof are asserted on the same word.
- fifo_level > need: only need bytes are read; the excess stays for the next word or fragment.

Optional Feature:
- Macro FRAG_READER_FLUSH_EN.
- Defined: adds input port flush (1 bit).
  - In REQ with flush=1 and 0 < fifo_level < need: read fifo_level bytes and emit that word with m_eof=1, terminating the fragment short.
  - frag_cnt increments and remaining reloads FRAG_LEN.
  - flush with fifo_level=0, or outside REQ, is ignored.
- Not defined: no flush port; a short fragment tail waits indefinitely for data.

Test Plan:
- Level/read: FRAG_LEN=6, m_ready=1. Write 0x12345678 with 4 bytes -> fifo_rd_en with index 4; 2 cycles later m_data=0x12345678, m_bytes=4, m_sof=1, m_eof=0.
- Fragment completion: continue with 0x11223344 written as 2 bytes -> read index 2; m_data=0x11220000, m_bytes=2, m_sof=0, m_eof=1; frag_cnt=1.
- Insufficient level: level=3, need=4 -> no fifo_rd_en for 20 cycles. Write 1 more byte -> read index 4 issued within 1 cycle.
- Backpressure: hold m_ready=0 for 5 cycles with level=8 -> m_data stable, m_valid=1, no second fifo_rd_en. Raise m_ready -> next read 1 cycle later.
- Reset mid-fragment: assert rst in OUT after the first word of a fragment.
  - All outputs return to 0 on the next edge; frag_cnt=0.
  - The next word after reset has m_sof=1 and m_bytes=4.
- Flush (FRAG_READER_FLUSH_EN): level=1, remaining=6, flush=1 -> read index 1; m_bytes=1, m_eof=1; frag_cnt increments.
